jstk2_spi_responder: RTL and testbench

SPI-slave responder that emulates the PmodJSTK2 joystick module on the far side of the `JSTK2_driver` master. It receives the master's 5-byte command packet (command plus four parameters) and shifts a 48-bit response frame back on MISO. The block lets the joystick path be exercised in simulation and on-board loopback without the physical Pmod, and can also stand in as a soft joystick fed from other logic.

---
 rtl/jstk2_spi_responder.sv | 246 ++++++++++++++++++++++++
 tb/tb_jstk2_spi_responder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/jstk2_spi_responder.sv
// -----------------------------------------------------------------------------
// jstk2_spi_responder
//
// SPI mode-0 slave that stands in for a PmodJSTK2 joystick. It receives a
// 5-byte command packet from the master (command + four parameters) and shifts
// a 48-bit response frame back on MISO, MSB first.
//
// SCLK, CS and MOSI are asynchronous to i_clk. Each passes through SYNC_STAGES
// flops, and SCLK/CS get one more flop for edge detection. Every action
// therefore lands SYNC_STAGES + 1 cycles after the raw pin edge.
//
// Parameters
//   SYNC_STAGES   synchronizer depth, 2 or 3
//
// Ports
//   i_clk         system clock
//   i_reset       synchronous, active-high reset
//   i_sclk        SPI clock from master (<= f(i_clk)/8)
//   i_cs          chip select from master, active-low
//   i_mosi        serial data from master
//   o_miso        serial data to master
//   i_tx_data     48-bit response frame, byte 0 in [47:40]; captured at CS fall
//   o_cmd         last committed command byte
//   o_param_1..4  last committed parameter bytes
//   o_cmd_valid   1-cycle pulse: frame ended on a byte boundary with >= 5 bytes
//   o_frame_err   1-cycle pulse: frame ended mid-byte or with < 5 bytes
//   o_busy        high while a frame is in progress
//
// Build option
//   JSTK2_RESP_LED_EN  adds o_led_r/o_led_g/o_led_b and o_led_upd. These are
//                      loaded from params 1..3 when a valid frame carries
//                      command 8'h84.
// -----------------------------------------------------------------------------
module jstk2_spi_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_sclk,
    input  logic        i_cs,
    input  logic        i_mosi,
    output logic        o_miso,
    input  logic [47:0] i_tx_data,
    output logic [7:0]  o_cmd,
    output logic [7:0]  o_param_1,
    output logic [7:0]  o_param_2,
    output logic [7:0]  o_param_3,
    output logic [7:0]  o_param_4,
    output logic        o_cmd_valid,
    output logic        o_frame_err,
    output logic        o_busy
`ifdef JSTK2_RESP_LED_EN
    ,
    output logic [7:0]  o_led_r,
    output logic [7:0]  o_led_g,
    output logic [7:0]  o_led_b,
    output logic        o_led_upd
`endif
);

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        SHIFT
    } state_e;

    // ---------------------------------------------------------------- sync
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   cs_prev_q,   cs_prev_d;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise =  sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s &  sclk_prev_q;
    assign cs_rise   =  cs_s   & ~cs_prev_q;
    assign cs_fall   = ~cs_s   &  cs_prev_q;

    // MOSI has no edge flop. Its last sync stage lines up in time with the
    // SCLK sample that produces sclk_rise.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], i_sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   i_cs};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], i_mosi};
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
    end

    // ---------------------------------------------------------------- core
    state_e           state_q,     state_d;
    logic [2:0]       bit_cnt_q,   bit_cnt_d;
    logic [2:0]       byte_cnt_q,  byte_cnt_d;   // saturates at 6
    logic [6:0]       rx_q,        rx_d;         // first 7 bits of the byte
    logic [47:0]      tx_q,        tx_d;
    logic [4:0][7:0]  shadow_q,    shadow_d;     // [0] = cmd, [1..4] = params
    logic [4:0][7:0]  data_q,      data_d;       // committed copy
    logic             cmd_valid_q, cmd_valid_d;
    logic             frame_err_q, frame_err_d;
`ifdef JSTK2_RESP_LED_EN
    logic [2:0][7:0]  led_q,       led_d;        // [2] = r, [1] = g, [0] = b
    logic             led_upd_q,   led_upd_d;
`endif

    logic [7:0] rx_byte;
    assign rx_byte = {rx_q, mosi_s};

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        shadow_d    = shadow_q;
        data_d      = data_q;
        cmd_valid_d = 1'b0;
        frame_err_d = 1'b0;
`ifdef JSTK2_RESP_LED_EN
        led_d       = led_q;
        led_upd_d   = 1'b0;
`endif

        unique case (state_q)
            // Wait out any frame already in flight when reset was released.
            WAIT_IDLE: begin
                if (cs_s) state_d = IDLE;
            end

            IDLE: begin
                if (cs_fall) begin
                    tx_d       = i_tx_data;
                    bit_cnt_d  = 3'd0;
                    byte_cnt_d = 3'd0;
                    state_d    = SHIFT;
                end
            end

            SHIFT: begin
                // CS rise takes priority over an SCLK edge seen in the same cycle.
                if (cs_rise) begin
                    state_d = IDLE;
                    tx_d    = '0;              // keep MISO low between frames
                    if (bit_cnt_q == 3'd0 && byte_cnt_q >= 3'd5) begin
                        cmd_valid_d = 1'b1;
                        data_d      = shadow_q;
`ifdef JSTK2_RESP_LED_EN
                        if (shadow_q[0] == 8'h84) begin
                            led_d     = {shadow_q[1], shadow_q[2], shadow_q[3]};
                            led_upd_d = 1'b1;
                        end
`endif
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    if (sclk_rise) begin
                        rx_d      = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            // Bytes 5 and later fall outside the five shadow slots.
                            if (byte_cnt_q < 3'd5) shadow_d[byte_cnt_q] = rx_byte;
                            if (byte_cnt_q != 3'd6) byte_cnt_d = byte_cnt_q + 3'd1;
                        end
                    end
                    if (sclk_fall) tx_d = {tx_q[46:0], 1'b0};
                end
            end

            default: state_d = WAIT_IDLE;
        endcase
    end

    // NOTE: sequential state is updated only with non-blocking assignments, so
    // every flop samples its pre-edge *_d value regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
            state_q     <= WAIT_IDLE;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            data_q      <= '0;
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef JSTK2_RESP_LED_EN
            led_q       <= '0;
            led_upd_q   <= 1'b0;
`endif
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            data_q      <= data_d;
            cmd_valid_q <= cmd_valid_d;
            frame_err_q <= frame_err_d;
`ifdef JSTK2_RESP_LED_EN
            led_q       <= led_d;
            led_upd_q   <= led_upd_d;
`endif
        end
    end

    // NOTE: the shadow bytes are left out of reset. A commit requires all five
    // slots to have been rewritten in the current frame, so their power-up
    // contents are never observable.
    always_ff @(posedge i_clk) begin
        shadow_q <= shadow_d;
    end

    // ---------------------------------------------------------------- outputs
    assign o_miso      = tx_q[47];
    assign o_cmd       = data_q[0];
    assign o_param_1   = data_q[1];
    assign o_param_2   = data_q[2];
    assign o_param_3   = data_q[3];
    assign o_param_4   = data_q[4];
    assign o_cmd_valid = cmd_valid_q;
    assign o_frame_err = frame_err_q;
    assign o_busy      = (state_q == SHIFT);
`ifdef JSTK2_RESP_LED_EN
    assign o_led_r     = led_q[2];
    assign o_led_g     = led_q[1];
    assign o_led_b     = led_q[0];
    assign o_led_upd   = led_upd_q;
`endif

endmodule

// File: tb/tb_jstk2_spi_responder.sv
// -----------------------------------------------------------------------------
// tb_jstk2_spi_responder
//
// Directed bench for jstk2_spi_responder. A behavioural SPI master runs at
// SCLK = clk/10. Expected values are written out by hand for each vector.
// -----------------------------------------------------------------------------
module tb_jstk2_spi_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk;
    logic        cs;
    logic        mosi;
    logic        miso;
    logic [47:0] tx_data;
    logic [7:0]  cmd, p1, p2, p3, p4;
    logic        cmd_valid, frame_err, busy;
`ifdef JSTK2_RESP_LED_EN
    logic [7:0]  led_r, led_g, led_b;
    logic        led_upd;
`endif

    always #5 clk = ~clk;

    jstk2_spi_responder #(.SYNC_STAGES(2)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_sclk      (sclk),
        .i_cs        (cs),
        .i_mosi      (mosi),
        .o_miso      (miso),
        .i_tx_data   (tx_data),
        .o_cmd       (cmd),
        .o_param_1   (p1),
        .o_param_2   (p2),
        .o_param_3   (p3),
        .o_param_4   (p4),
        .o_cmd_valid (cmd_valid),
        .o_frame_err (frame_err),
        .o_busy      (busy)
`ifdef JSTK2_RESP_LED_EN
        ,
        .o_led_r     (led_r),
        .o_led_g     (led_g),
        .o_led_b     (led_b),
        .o_led_upd   (led_upd)
`endif
    );

    // ------------------------------------------------------------ checking
    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------ pulse monitor
    int valid_cnt = 0;
    int err_cnt   = 0;
    int both_cnt  = 0;
    int led_ok    = 0;
    int led_stray = 0;

    always @(negedge clk) begin
        if (cmd_valid) valid_cnt++;
        if (frame_err) err_cnt++;
        if (cmd_valid && frame_err) both_cnt++;
`ifdef JSTK2_RESP_LED_EN
        if (led_upd) begin
            if (cmd_valid) led_ok++;
            else           led_stray++;
        end
`endif
    end

    // ------------------------------------------------------------ SPI master
    logic [63:0] last_rx;
    int          last_lat;
    logic [7:0]  last_cmd_at;
    logic        last_wide;
    logic        last_busy;

    // Sends bits[63 -: nbits] MSB first. rst_bit pulses reset while that bit
    // is set up, chg_bit alters i_tx_data mid-frame, and coincide raises CS in
    // the same cycle as the final SCLK rise.
    task automatic spi_frame(input logic [63:0] bits, input int nbits,
                             input int rst_bit, input int chg_bit, input bit coincide);
        last_rx     = '0;
        last_lat    = -1;
        last_cmd_at = 8'h00;
        last_wide   = 1'b0;
        @(negedge clk);
        cs = 1'b0;
        repeat (10) @(negedge clk);
        last_busy = busy;
        for (int i = 0; i < nbits; i++) begin
            mosi = bits[63-i];
            if (i == rst_bit) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                repeat (4) @(negedge clk);
            end else begin
                repeat (5) @(negedge clk);
            end
            if (i == chg_bit) tx_data = 48'hDEAD_BEEF_CAFE;
            sclk = 1'b1;
            if (coincide && i == nbits - 1) begin
                cs = 1'b0 | 1'b1;
            end else begin
                last_rx[63-i] = miso;
                repeat (5) @(negedge clk);
                sclk = 1'b0;
            end
        end
        if (!coincide) begin
            repeat (5) @(negedge clk);
            cs = 1'b1;
        end
        // Latency from the raw CS rise, in clock cycles; bounded at 20.
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (last_lat < 0 && (cmd_valid || frame_err)) begin
                last_lat    = k;
                last_cmd_at = cmd;
            end else if (last_lat > 0 && k == last_lat + 1) begin
                last_wide = cmd_valid || frame_err;
            end
        end
        sclk = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    // ------------------------------------------------------------ stimulus
    int v0, e0;

    initial begin
        rst = 1'b1; sclk = 1'b0; cs = 1'b1; mosi = 1'b0; tx_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_miso",  64'(miso), 64'h0);
        check("rst_cmd",   64'(cmd), 64'h0);
        check("rst_params", 64'({p1, p2, p3, p4}), 64'h0);
        check("rst_pulses", 64'({cmd_valid, frame_err}), 64'h0);
        check("rst_busy",  64'(busy), 64'h0);
`ifdef JSTK2_RESP_LED_EN
        check("rst_led",   64'({led_r, led_g, led_b, led_upd}), 64'h0);
`endif
        repeat (5) @(negedge clk);

        // Basic command FF 11 22 33 44
        v0 = valid_cnt; e0 = err_cnt;
        spi_frame({40'hFF_11_22_33_44, 24'h0}, 40, -1, -1, 1'b0);
        check("basic_valid", 64'(valid_cnt - v0), 64'd1);
        check("basic_err",   64'(err_cnt - e0), 64'd0);
        check("basic_lat",   64'(last_lat), 64'd3);
        check("basic_width", 64'(last_wide), 64'd0);
        check("basic_cmd_at_pulse", 64'(last_cmd_at), 64'hFF);
        check("basic_busy_mid", 64'(last_busy), 64'd1);
        check("basic_busy_after", 64'(busy), 64'd0);
        check("basic_regs", 64'({cmd, p1, p2, p3, p4}), 64'hFF_11_22_33_44);

        // Aborted frame: cmd 71, CS rises after 12 bits
        v0 = valid_cnt; e0 = err_cnt;
        spi_frame({16'h71_AB, 48'h0}, 12, -1, -1, 1'b0);
        check("abort_err",   64'(err_cnt - e0), 64'd1);
        check("abort_valid", 64'(valid_cnt - v0), 64'd0);
        check("abort_lat",   64'(last_lat), 64'd3);
        check("abort_regs",  64'({cmd, p1, p2, p3, p4}), 64'hFF_11_22_33_44);

        // Four whole bytes only: byte count below five
        v0 = valid_cnt; e0 = err_cnt;
        spi_frame({32'h12_34_56_78, 32'h0}, 32, -1, -1, 1'b0);
        check("short_err",   64'(err_cnt - e0), 64'd1);
        check("short_valid", 64'(valid_cnt - v0), 64'd0);
        check("short_cmd",   64'(cmd), 64'hFF);

        // Response path: 56 bits clocked, tx_data altered at bit 10
        tx_data = 48'h0123_4567_89AB;
        v0 = valid_cnt; e0 = err_cnt;
        spi_frame({40'h5A_01_02_03_04, 24'hEE_EE_EE}, 56, -1, 10, 1'b0);
        check("resp_miso",  last_rx, 64'h0123_4567_89AB_0000);
        check("resp_valid", 64'(valid_cnt - v0), 64'd1);
        check("resp_err",   64'(err_cnt - e0), 64'd0);
        check("resp_regs",  64'({cmd, p1, p2, p3, p4}), 64'h5A_01_02_03_04);
        check("resp_miso_idle", 64'(miso), 64'h0);

        // Reset pulse at bit 20; the frame must be dropped
        v0 = valid_cnt; e0 = err_cnt;
        spi_frame({40'h71_55_66_77_88, 24'h0}, 40, 20, -1, 1'b0);
        check("rstmid_pulses", 64'((valid_cnt - v0) + (err_cnt - e0)), 64'd0);
        check("rstmid_regs",   64'({cmd, p1, p2, p3, p4}), 64'h0);
        check("rstmid_busy",   64'(busy), 64'd0);
        v0 = valid_cnt;
        spi_frame({40'h71_00_00_00_00, 24'h0}, 40, -1, -1, 1'b0);
        check("rstmid_next_valid", 64'(valid_cnt - v0), 64'd1);
        check("rstmid_next_cmd",   64'(cmd), 64'h71);

        // CS rise coincident with the 41st SCLK rise
        v0 = valid_cnt; e0 = err_cnt;
        spi_frame({40'hC3_01_02_03_04, 24'hFF_FF_FF}, 41, -1, -1, 1'b1);
        check("coin_valid", 64'(valid_cnt - v0), 64'd1);
        check("coin_err",   64'(err_cnt - e0), 64'd0);
        check("coin_lat",   64'(last_lat), 64'd3);
        check("coin_regs",  64'({cmd, p1, p2, p3, p4}), 64'hC3_01_02_03_04);

        // LED command 84 10 20 30 00
        v0 = valid_cnt;
        spi_frame({40'h84_10_20_30_00, 24'h0}, 40, -1, -1, 1'b0);
        check("led_valid", 64'(valid_cnt - v0), 64'd1);
        check("led_regs",  64'({cmd, p1, p2, p3, p4}), 64'h84_10_20_30_00);
`ifdef JSTK2_RESP_LED_EN
        check("led_rgb",   64'({led_r, led_g, led_b}), 64'h10_20_30);
        check("led_upd_coincident", 64'(led_ok), 64'd1);
        check("led_upd_stray", 64'(led_stray), 64'd0);
`endif

        check("never_both_pulses", 64'(both_cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
